// File: rtl/bus_demux_9ch.sv
// bus_demux_9ch: routes one data word per accepted transfer into one of nine
// registered channel outputs, with a one-cycle one-hot load strobe, a sticky
// error flag for out-of-range selects, and a two-state accept/hold handshake.
module bus_demux_9ch #(
    parameter int word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] data_in,
    input  logic [4:0]           sel,
    input  logic                 in_valid,
    input  logic                 clr,
    output logic                 in_ready,
    output logic [word_size-1:0] data_a,
    output logic [word_size-1:0] data_b,
    output logic [word_size-1:0] data_c,
    output logic [word_size-1:0] data_d,
    output logic [word_size-1:0] data_e,
    output logic [word_size-1:0] data_f,
    output logic [word_size-1:0] data_g,
    output logic [word_size-1:0] data_h,
    output logic [word_size-1:0] data_i,
    output logic [8:0]           load_strb,
    output logic                 err
);

    // state | meaning
    // IDLE  | ready; a valid word is accepted at the next edge
    // HOLD  | one-cycle recovery after an in-range write; in_valid ignored
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int N_CH = 9;

    state_t               state_q, state_d;
    logic [word_size-1:0] ch_q [N_CH];
    logic [word_size-1:0] ch_d [N_CH];
    logic [8:0]           strb_q, strb_d;
    logic                 err_q, err_d;

    // Next-state, channel load and strobe decode; clr overrides any transfer.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        strb_d  = '0;
        err_d   = err_q;
        if (clr) begin
            state_d = IDLE;
            err_d   = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                ch_d[k] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (sel < 5'd9) begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (sel == 5'(k)) begin
                                    ch_d[k]   = data_in;
                                    strb_d[k] = 1'b1;
                                end
                            end
                            state_d = HOLD;
                        end else begin
                            // Out-of-range select: flag it, write nothing, stay ready.
                            err_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            strb_q  <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                ch_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
            for (int k = 0; k < N_CH; k++) begin
                ch_q[k] <= ch_d[k];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign load_strb = strb_q;
    assign err       = err_q;
    assign data_a    = ch_q[0];
    assign data_b    = ch_q[1];
    assign data_c    = ch_q[2];
    assign data_d    = ch_q[3];
    assign data_e    = ch_q[4];
    assign data_f    = ch_q[5];
    assign data_g    = ch_q[6];
    assign data_h    = ch_q[7];
    assign data_i    = ch_q[8];

endmodule

// File: tb/tb_bus_demux_9ch.sv
// Testbench for bus_demux_9ch: directed scenarios followed by a random stream,
// all compared every cycle against a behavioural model of the routing rules.
module tb_bus_demux_9ch;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [4:0] sel;
    logic       in_valid;
    logic       clr;
    logic       in_ready;
    logic [7:0] data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h, data_i;
    logic [8:0] load_strb;
    logic       err;

    logic [7:0] dut_ch [9];

    // Behavioural model: channel contents, last strobe, error flag, and
    // whether the block is recovering from a write made at the previous edge.
    logic [7:0] m_ch [9];
    logic [8:0] m_strb;
    logic       m_err;
    logic       m_busy;

    int vectors;
    int miscompares;

    bus_demux_9ch #(.word_size(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .clr       (clr),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_c    (data_c),
        .data_d    (data_d),
        .data_e    (data_e),
        .data_f    (data_f),
        .data_g    (data_g),
        .data_h    (data_h),
        .data_i    (data_i),
        .load_strb (load_strb),
        .err       (err)
    );

    assign dut_ch[0] = data_a;
    assign dut_ch[1] = data_b;
    assign dut_ch[2] = data_c;
    assign dut_ch[3] = data_d;
    assign dut_ch[4] = data_e;
    assign dut_ch[5] = data_f;
    assign dut_ch[6] = data_g;
    assign dut_ch[7] = data_h;
    assign dut_ch[8] = data_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_ch[k] = 8'h00;
        m_strb = '0;
        m_err  = 1'b0;
        m_busy = 1'b0;
    endtask

    // Apply the routing rules for one rising edge using the driven inputs.
    task automatic model_edge();
        int idx;
        idx = int'(sel);
        if (clr) begin
            model_reset();
        end else if (!m_busy && in_valid) begin
            if (idx < 9) begin
                m_ch[idx] = data_in;
                m_strb    = 9'(1) << idx;
                m_busy    = 1'b1;
            end else begin
                m_err  = 1'b1;
                m_strb = '0;
            end
        end else begin
            m_strb = '0;
            m_busy = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        for (int k = 0; k < 9; k++) begin
            assert (dut_ch[k] === m_ch[k]) else begin
                miscompares++;
                $error("FAIL %s ch%0d observed=%h expected=%h", tag, k, dut_ch[k], m_ch[k]);
            end
        end
        assert (load_strb === m_strb) else begin
            miscompares++;
            $error("FAIL %s load_strb observed=%b expected=%b", tag, load_strb, m_strb);
        end
        assert (err === m_err) else begin
            miscompares++;
            $error("FAIL %s err observed=%b expected=%b", tag, err, m_err);
        end
        assert (in_ready === !m_busy) else begin
            miscompares++;
            $error("FAIL %s in_ready observed=%b expected=%b", tag, in_ready, !m_busy);
        end
        assert ($countones(load_strb) <= 1) else begin
            miscompares++;
            $error("FAIL %s strobe_onehot observed=%b expected=at most one bit", tag, load_strb);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [7:0] d, input logic c);
        in_valid = v;
        sel      = s;
        data_in  = d;
        clr      = c;
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic step(input logic v, input logic [4:0] s, input logic [7:0] d, input logic c,
                        input string tag);
        @(negedge clk);
        drive(v, s, d, c);
        edge_check(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(1'b0, 5'd0, 8'h00, 1'b0);
        model_reset();

        // Reset state
        rst = 1'b1;
        #1;
        check("reset");
        #2;
        rst = 1'b0;
        edge_check("post_reset_idle");

        // Single write to channel d
        step(1'b1, 5'd3, 8'hA5, 1'b0, "write_d");
        assert (data_d === 8'hA5) else begin
            miscompares++;
            $error("FAIL write_d_const observed=%h expected=a5", data_d);
        end
        assert (load_strb === 9'b000001000) else begin
            miscompares++;
            $error("FAIL write_d_strb observed=%b expected=000001000", load_strb);
        end
        step(1'b0, 5'd3, 8'hA5, 1'b0, "write_d_after");

        // Back-to-back requests with in_valid held: second lands two edges later
        step(1'b1, 5'd0, 8'h11, 1'b0, "b2b_first");
        step(1'b1, 5'd8, 8'h22, 1'b0, "b2b_hold_ignored");
        assert (data_i === 8'h00) else begin
            miscompares++;
            $error("FAIL b2b_hold_nowrite observed=%h expected=00", data_i);
        end
        step(1'b1, 5'd8, 8'h22, 1'b0, "b2b_second");
        assert (data_a === 8'h11 && data_i === 8'h22) else begin
            miscompares++;
            $error("FAIL b2b_values observed=%h/%h expected=11/22", data_a, data_i);
        end
        step(1'b0, 5'd0, 8'h00, 1'b0, "b2b_idle");

        // Out-of-range select sets sticky err
        step(1'b1, 5'd9, 8'hFF, 1'b0, "oor_sel9");
        step(1'b1, 5'd31, 8'hEE, 1'b0, "oor_sel31");
        step(1'b1, 5'd1, 8'h33, 1'b0, "err_sticky_write");
        step(1'b0, 5'd1, 8'h33, 1'b0, "err_sticky_idle");
        assert (err === 1'b1) else begin
            miscompares++;
            $error("FAIL err_sticky_const observed=%b expected=1", err);
        end

        // Fill all nine channels, then clr collides with a valid word
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 5'(k), 8'(k + 1), 1'b0, "fill");
            step(1'b0, 5'(k), 8'(k + 1), 1'b0, "fill_gap");
        end
        step(1'b1, 5'd2, 8'h77, 1'b1, "clr_wins");
        assert (data_c === 8'h00 && err === 1'b0) else begin
            miscompares++;
            $error("FAIL clr_wins_const observed=%h/%b expected=00/0", data_c, err);
        end
        step(1'b0, 5'd2, 8'h77, 1'b0, "clr_after");

        // Asynchronous reset during HOLD
        step(1'b1, 5'd4, 8'h5A, 1'b0, "write_e");
        #2;
        drive(1'b0, 5'd0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_hold");
        assert (data_e === 8'h00 && in_ready === 1'b1) else begin
            miscompares++;
            $error("FAIL async_rst_const observed=%h/%b expected=00/1", data_e, in_ready);
        end

        // First transfer on the first edge after release
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd5, 8'hC3, 1'b0);
        edge_check("first_after_rst");

        // Random stream
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
            step(1'($urandom_range(0, 3) != 0), rs, 8'($urandom),
                 1'($urandom_range(0, 31) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
